// File: rtl/risc16_uart_tx_pkg.sv
// ============================================================================
//  Module   : risc16_mmio_pkg
//  Brief    : Shared register offsets, status bit indices and the UART
//             transmitter state type for the risc16 MMIO UART slice.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package risc16_mmio_pkg;

  // Register offsets, indexed by daddr[2:1]
  localparam logic [1:0] OFF_TXDATA  = 2'd0;
  localparam logic [1:0] OFF_STATUS  = 2'd1;
  localparam logic [1:0] OFF_DIVISOR = 2'd2;

  // STATUS register bit positions
  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_BUSY    = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage

`default_nettype wire

// File: rtl/risc16_uart_tx_if.sv
// ============================================================================
//  Module   : risc16_uart_tx_if
//  Brief    : risc16 data-bus signals seen by a memory-mapped peripheral.
//             master = core side, slave = peripheral side.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface risc16_uart_tx_if;

  logic [15:0] daddr;
  logic [15:0] ddout;
  logic        doe;
  logic        dwe0;
  logic        dwe1;
  logic [15:0] rdata;
  logic        hit;

  modport master (
    output daddr, ddout, doe, dwe0, dwe1,
    input  rdata, hit
  );

  modport slave (
    input  daddr, ddout, doe, dwe0, dwe1,
    output rdata, hit
  );

endinterface

`default_nettype wire

// File: rtl/risc16_uart_tx_sync_fifo.sv
// ============================================================================
//  Module   : sync_fifo
//  Brief    : Single-clock FIFO with first-word-fall-through output.
//             A push while full is dropped even if a pop happens in the
//             same cycle; a pop while empty is ignored.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  wire logic                   clk,
  input  wire logic                   rst,
  input  wire logic                   push_i,
  input  wire logic                   pop_i,
  input  wire logic [WIDTH-1:0]       din_i,
  output logic      [WIDTH-1:0]       dout_o,
  output logic                        full_o,
  output logic                        empty_o,
  output logic      [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [CW-1:0]    cnt_q;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign full_o    = (cnt_q == CW'(DEPTH));
  assign empty_o   = (cnt_q == '0);
  assign count_o   = cnt_q;
  assign dout_o    = mem_q[rd_q];
  assign w_push_ok = push_i & ~full_o;
  assign w_pop_ok  = pop_i & ~empty_o;

  // Storage array; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      mem_q[wr_q] <= din_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (w_push_ok) wr_q <= wr_q + AW'(1);
      if (w_pop_ok)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(w_push_ok) - CW'(w_pop_ok);
    end
  end

endmodule

`default_nettype wire

// File: rtl/risc16_uart_tx.sv
// ============================================================================
//  Module   : risc16_uart_tx
//  Brief    : Memory-mapped 8N1 UART transmitter on the risc16 data bus.
//             Register decode, TX FIFO, baud divisor and bit-level FSM.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module risc16_uart_tx
  import risc16_mmio_pkg::*;
#(
  parameter logic [15:0] BASE    = 16'hFF00,
  parameter int          DEPTH   = 4,
  parameter logic [15:0] DIV_RST = 16'd433
) (
  input  wire logic          clk,
  input  wire logic          rst,
  risc16_uart_tx_if.slave    bus,
  output logic               txd,
  output logic               tx_busy
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [1:0]    w_off;
  logic          w_hit;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [7:0]    w_head;
  logic [CW-1:0] w_count;
  logic          w_ovf_set;
  logic          w_ovf_clr;
  logic [15:0]   w_status;
  logic [15:0]   w_rdata;
  logic          w_unused;

  logic [15:0]   divisor_q;
  logic          ovf_q;
  uart_state_t   state_q;
  logic          txd_q;
  logic [7:0]    shift_q;
  logic [2:0]    bit_q;
  logic [15:0]   baud_q;

  // Address decode: 8-byte window, word offset from daddr[2:1]
  assign w_off     = bus.daddr[2:1];
  assign w_hit     = (bus.daddr[15:3] == BASE[15:3]);
  assign w_push    = w_hit & (w_off == OFF_TXDATA) & bus.dwe1;
  assign w_pop     = (state_q == IDLE) & ~w_empty;
  assign w_ovf_set = w_push & w_full;
  assign w_ovf_clr = w_hit & (w_off == OFF_STATUS) & bus.dwe1 & bus.ddout[ST_OVF];
  assign w_unused  = bus.daddr[0];

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .din_i   (bus.ddout[7:0]),
    .dout_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_count)
  );

  // STATUS word assembly and combinational read mux
  always_comb begin
    w_status                       = '0;
    w_status[ST_FULL]              = w_full;
    w_status[ST_EMPTY]             = w_empty;
    w_status[ST_BUSY]              = (state_q != IDLE);
    w_status[ST_OVF]               = ovf_q;
    w_status[ST_CNT_LSB +: 4]      = 4'(w_count);
    w_rdata                        = '0;
    if (w_hit && bus.doe) begin
      case (w_off)
        OFF_STATUS:  w_rdata = w_status;
        OFF_DIVISOR: w_rdata = divisor_q;
        default:     w_rdata = '0;
      endcase
    end
  end

  assign bus.rdata = w_rdata;
  assign bus.hit   = w_hit;
  assign txd       = txd_q;
  assign tx_busy   = (state_q != IDLE) | ~w_empty;

  // Control registers: sticky overflow (set beats clear) and byte-lane divisor
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q     <= 1'b0;
      divisor_q <= DIV_RST;
    end else begin
      ovf_q <= w_ovf_set | (ovf_q & ~w_ovf_clr);
      if (w_hit && (w_off == OFF_DIVISOR) && bus.dwe0) divisor_q[15:8] <= bus.ddout[15:8];
      if (w_hit && (w_off == OFF_DIVISOR) && bus.dwe1) divisor_q[7:0]  <= bus.ddout[7:0];
    end
  end

  // Bit-level serialiser; the baud counter reloads from DIVISOR at each bit start
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      txd_q   <= 1'b1;
      shift_q <= '0;
      bit_q   <= '0;
      baud_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          txd_q <= 1'b1;
          if (!w_empty) begin
            shift_q <= w_head;
            baud_q  <= divisor_q;
            txd_q   <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (baud_q == 16'd0) begin
            baud_q  <= divisor_q;
            bit_q   <= 3'd0;
            txd_q   <= shift_q[0];
            state_q <= DATA;
          end else begin
            baud_q <= baud_q - 16'd1;
          end
        end
        DATA: begin
          if (baud_q == 16'd0) begin
            baud_q <= divisor_q;
            if (bit_q == 3'd7) begin
              txd_q   <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_q   <= bit_q + 3'd1;
              shift_q <= {1'b0, shift_q[7:1]};
              txd_q   <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q - 16'd1;
          end
        end
        STOP: begin
          txd_q <= 1'b1;
          if (baud_q == 16'd0) begin
            state_q <= IDLE;
          end else begin
            baud_q <= baud_q - 16'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          txd_q   <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_risc16_uart_tx.sv
// ============================================================================
//  Module   : tb_risc16_uart_tx
//  Brief    : Scoreboard bench for risc16_uart_tx. Stores push expected bytes
//             into a queue; a txd monitor decodes frames against the queue and
//             the bench-tracked divisor. Register reads use a register-map model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_risc16_uart_tx;

  localparam logic [15:0] BASE    = 16'hFF00;
  localparam int          DEPTH   = 4;
  localparam logic [15:0] DIV_RST = 16'd433;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic txd;
  logic tx_busy;

  risc16_uart_tx_if bus ();

  risc16_uart_tx #(
    .BASE    (BASE),
    .DEPTH   (DEPTH),
    .DIV_RST (DIV_RST)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .txd     (txd),
    .tx_busy (tx_busy)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0]  sb[$];
  logic [15:0] m_div;
  logic        m_ovf;
  int          vec  = 0;
  int          miss = 0;

  // Monitor state
  int          m_state   = 0;
  int          m_bit     = 0;
  int          m_left    = 0;
  bit          m_first   = 1'b0;
  bit          frame_bad = 1'b0;
  bit          mon_busy  = 1'b0;
  bit          mon_abort = 1'b0;
  logic [7:0]  cur;
  int          bad_bit;
  logic        bad_act;
  logic        bad_exp;
  logic        exp_lvl;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic bit in_window(input logic [15:0] a);
    logic [15:0] b;
    b = BASE;
    return a[15:3] == b[15:3];
  endfunction

  function automatic logic [15:0] exp_rdata(input logic [15:0] a, input bit oe);
    logic [15:0] r;
    int c;
    r = '0;
    c = sb.size();
    if (oe && in_window(a)) begin
      case (a[2:1])
        2'd1: begin
          r[0]    = (c == DEPTH);
          r[1]    = (c == 0);
          r[2]    = mon_busy;
          r[3]    = m_ovf;
          r[11:8] = 4'(c);
        end
        2'd2:    r = m_div;
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  task automatic bus_idle();
    bus.daddr = '0;
    bus.ddout = '0;
    bus.doe   = 1'b0;
    bus.dwe0  = 1'b0;
    bus.dwe1  = 1'b0;
  endtask

  task automatic model_write(input logic [15:0] a, input logic [15:0] d, input bit w0, input bit w1);
    if (in_window(a)) begin
      case (a[2:1])
        2'd0: if (w1) begin
          if (sb.size() >= DEPTH) m_ovf = 1'b1;
          else sb.push_back(d[7:0]);
        end
        2'd1: if (w1 && d[3]) m_ovf = 1'b0;
        2'd2: begin
          if (w0) m_div[15:8] = d[15:8];
          if (w1) m_div[7:0]  = d[7:0];
        end
        default: ;
      endcase
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d, input bit w0, input bit w1);
    @(negedge clk);
    bus.daddr = a;
    bus.ddout = d;
    bus.doe   = 1'b0;
    bus.dwe0  = w0;
    bus.dwe1  = w1;
    @(posedge clk);
    model_write(a, d, w0, w1);
    #1 bus_idle();
  endtask

  task automatic rd_chk(input string name, input logic [15:0] a, input bit oe);
    @(negedge clk);
    bus.daddr = a;
    bus.doe   = oe;
    #1;
    check({name, "_rdata"}, bus.rdata, exp_rdata(a, oe));
    check({name, "_hit"}, 16'(bus.hit), 16'(in_window(a)));
    bus_idle();
  endtask

  task automatic do_reset(input bit with_write);
    @(negedge clk);
    rst = 1'b1;
    if (with_write) begin
      bus.daddr = BASE;
      bus.ddout = 16'h00EE;
      bus.dwe1  = 1'b1;
    end
    @(posedge clk);
    sb.delete();
    m_ovf     = 1'b0;
    m_div     = DIV_RST;
    mon_abort = 1'b1;
    #1 bus_idle();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int bound);
    int n;
    n = 0;
    while (!(sb.size() == 0 && m_state == 0 && !mon_busy) && n < bound) begin
      @(negedge clk);
      #2;
      n++;
    end
    check({name, "_timeout"}, 16'(n >= bound), 16'd0);
  endtask

  task automatic wait_bit(input string name, input int b, input int bound);
    int n;
    n = 0;
    while (!(m_state == 1 && m_bit == b) && n < bound) begin
      @(negedge clk);
      #2;
      n++;
    end
    check({name, "_timeout"}, 16'(n >= bound), 16'd0);
  endtask

  // Frame monitor: decodes txd on falling clock edges against the scoreboard
  always @(negedge clk) begin
    if (mon_abort) begin
      mon_abort = 1'b0;
      m_state   = 0;
      mon_busy  = 1'b0;
    end else begin
      if (m_state == 0 && txd === 1'b0) begin
        vec++;
        if (sb.size() == 0) begin
          miss++;
          $display("FAIL unexpected_frame: got txd=0 with empty queue, required txd=1");
          m_state = 3;
        end else begin
          cur       = sb.pop_front();
          m_state   = 1;
          m_bit     = 0;
          m_first   = 1'b1;
          frame_bad = 1'b0;
          mon_busy  = 1'b1;
        end
      end
      if (m_state == 1) begin
        if (m_first) begin
          m_left  = int'(m_div);
          m_first = 1'b0;
        end
        exp_lvl = (m_bit == 0) ? 1'b0 : (m_bit == 9) ? 1'b1 : cur[m_bit-1];
        if (txd !== exp_lvl && !frame_bad) begin
          frame_bad = 1'b1;
          bad_bit   = m_bit;
          bad_act   = txd;
          bad_exp   = exp_lvl;
        end
        if (m_left == 0) begin
          m_bit++;
          m_first = 1'b1;
          if (m_bit == 10) m_state = 2;
        end else begin
          m_left--;
        end
      end else if (m_state == 2) begin
        if (txd !== 1'b1 && !frame_bad) begin
          frame_bad = 1'b1;
          bad_bit   = 10;
          bad_act   = txd;
          bad_exp   = 1'b1;
        end
        if (frame_bad) begin
          miss++;
          $display("FAIL frame_%02h: bit %0d txd=%b required %b", cur, bad_bit, bad_act, bad_exp);
        end
        mon_busy = 1'b0;
        m_state  = 0;
      end else if (m_state == 3) begin
        if (txd === 1'b1) m_state = 0;
      end
    end
  end

  // Watchdog
  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit low_seen;
    int r;
    bus_idle();
    m_div = DIV_RST;
    m_ovf = 1'b0;

    // Reset state, with a store attempted in the reset cycle
    do_reset(1'b1);
    check("reset_txd", 16'(txd), 16'd1);
    check("reset_busy", 16'(tx_busy), 16'd0);
    rd_chk("reset_status", BASE + 16'd2, 1'b1);
    rd_chk("reset_div", BASE + 16'd4, 1'b1);

    // Single frame 0xA5 at DIVISOR=3 and start latency
    wr(BASE + 16'd4, 16'd3, 1'b1, 1'b1);
    wr(BASE, 16'h00A5, 1'b1, 1'b1);
    @(negedge clk);
    check("e0_txd_high", 16'(txd), 16'd1);
    check("e0_busy", 16'(tx_busy), 16'd1);
    @(negedge clk);
    check("e1_txd_low", 16'(txd), 16'd0);
    wait_idle("frame_a5", 200);
    check("busy_after_a5", 16'(tx_busy), 16'd0);

    // Two queued bytes behind an active frame; read gating and window edges
    wr(BASE, 16'h0031, 1'b0, 1'b1);
    wr(BASE, 16'h0032, 1'b0, 1'b1);
    wr(BASE, 16'h0033, 1'b0, 1'b1);
    rd_chk("status_two_queued", BASE + 16'd2, 1'b1);
    rd_chk("status_no_doe", BASE + 16'd2, 1'b0);
    rd_chk("below_window", BASE - 16'd2, 1'b1);
    rd_chk("above_window", BASE + 16'd8, 1'b1);
    rd_chk("reserved", BASE + 16'd6, 1'b1);
    rd_chk("txdata_reads_zero", BASE, 1'b1);
    wait_idle("frames_3x", 500);

    // Byte-lane divisor writes and high-lane-only store to TXDATA
    wr(BASE + 16'd5, 16'h000C, 1'b0, 1'b1);
    wr(BASE + 16'd4, 16'h0100, 1'b1, 1'b0);
    rd_chk("div_lanes", BASE + 16'd4, 1'b1);
    wr(BASE, 16'h7700, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    rd_chk("dwe0_no_push", BASE + 16'd2, 1'b1);

    // Overflow at DIVISOR=0: sixth back-to-back store is dropped
    wr(BASE + 16'd4, 16'd0, 1'b1, 1'b1);
    for (int k = 0; k < 6; k++) wr(BASE, 16'(8'h11 + k), 1'b0, 1'b1);
    rd_chk("status_ovf", BASE + 16'd2, 1'b1);
    wr(BASE + 16'd2, 16'h0008, 1'b0, 1'b1);
    rd_chk("status_ovf_clr", BASE + 16'd2, 1'b1);
    wait_idle("frames_ovf", 500);

    // Divisor change 3 -> 7 in the middle of data bit 3
    wr(BASE + 16'd4, 16'd3, 1'b1, 1'b1);
    wr(BASE, 16'h005A, 1'b0, 1'b1);
    wait_bit("midbit", 3, 200);
    wr(BASE + 16'd4, 16'd7, 1'b1, 1'b1);
    wait_idle("frame_midbit", 300);

    // Reset during DATA with three bytes queued
    wr(BASE + 16'd4, 16'd3, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) wr(BASE, 16'(8'hC0 + k), 1'b0, 1'b1);
    wait_bit("pre_reset", 4, 200);
    do_reset(1'b1);
    check("rst_mid_txd", 16'(txd), 16'd1);
    check("rst_mid_busy", 16'(tx_busy), 16'd0);
    rd_chk("rst_mid_status", BASE + 16'd2, 1'b1);
    rd_chk("rst_mid_div", BASE + 16'd4, 1'b1);
    low_seen = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (txd !== 1'b1) low_seen = 1'b1;
    end
    check("rst_no_frames", 16'(low_seen), 16'd0);

    // Randomised traffic
    wr(BASE + 16'd4, 16'd1, 1'b1, 1'b1);
    for (int i = 0; i < 80; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 40) begin
        wr(BASE, 16'($urandom), 1'($urandom_range(0, 1)), 1'b1);
      end else if (r < 45) begin
        wr(BASE, 16'($urandom), 1'b1, 1'b0);
      end else if (r < 70) begin
        if (r < 65) rd_chk("rand_rd", BASE + 16'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0));
        else        rd_chk("rand_rd_out", BASE + 16'd8 + 16'($urandom_range(0, 255)), 1'b1);
      end else if (r < 80) begin
        wr(BASE + 16'd2, 16'($urandom), 1'($urandom_range(0, 1)), 1'b1);
      end else if (r < 85) begin
        wr(BASE + 16'd6, 16'($urandom), 1'b1, 1'b1);
      end else if (r < 93) begin
        for (int k = 0; k < 6; k++) wr(BASE, 16'($urandom), 1'b0, 1'b1);
        rd_chk("rand_burst_status", BASE + 16'd2, 1'b1);
      end else begin
        wait_idle("rand_div_idle", 2000);
        wr(BASE + 16'd4, 16'($urandom_range(0, 2)), 1'b1, 1'b1);
        rd_chk("rand_div", BASE + 16'd4, 1'b1);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    wait_idle("final", 5000);
    rd_chk("final_status", BASE + 16'd2, 1'b1);
    check("final_busy", 16'(tx_busy), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

`default_nettype wire
